apple1_dsp_port: RTL and testbench
==================================

// Module: apple1_dsp_port
// PURPOSE
//  Display output port at $D012/$D013, between the CPU bus and the video terminal.
//  - Replaces the constant "always ready" display status with a real busy flag.
//  - Buffers CPU character writes in a small FIFO.
//  - Releases characters to the terminal at Apple-1 speed: one char per video frame, or unpaced.
//  - Bit7 of $D012 reads 1 while the port cannot accept a character, as original software polls.
// PARAMETERS
//  DEPTH        16      FIFO entries; power of two, 2..16
//  PACE_CYCLES  116667  clk7 cycles held after each char (7 MHz / 60 Hz)
// PORTS
//  clk7        in   1  7 MHz master clock; all logic on rising edge
//  rst_n       in   1  synchronous reset, active low
//  cpu_clken   in   1  CPU clock enable; bus side acts only when high
//  cs          in   1  chip select, decoded for $D012..$D013
//  address     in   1  0 = DSP ($D012), 1 = DSPCR ($D013)
//  we          in   1  CPU write strobe
//  din         in   8  CPU write data
//  dout        out  8  CPU read data (combinational mux of registered state)
//  fast        in   1  1 = skip pacing hold
//  flush       in   1  clear-screen request; empties port
//  term_valid  out  1  character available to terminal
//  term_char   out  7  ASCII character, bit7 of CPU data dropped
//  term_ready  in   1  terminal accepts term_char when term_valid & term_ready
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - count=0, ovf=0, last=0, state=IDLE, hold counter=0
//   - term_valid=0, term_char=0
//   - Reset mid-transfer discards the FIFO and any presented char.
//  bus_wr = cs & we & cpu_clken.  bus_rd = cs & ~we & cpu_clken.
//  Write DSP:
//   - push din[6:0] and set last=din[6:0] when count<DEPTH or a pop happens the same cycle.
//   - Otherwise drop the char and set ovf=1 (sticky).
//  Write DSPCR: ignored.
//  Read DSP: dout = {busy, last}; busy = (count==DEPTH).
//  Read DSPCR: dout = {ovf, 2'b00, count[4:0]}. bus_rd on DSPCR clears ovf at that edge.
//   - If a set occurs in the same cycle, the set wins.
//  dout is 8'h00 when cs=0.
//  Output FSM:
//   - IDLE:
//     - if count!=0: pop head into term_char, term_valid<=1, go PRESENT (registered; 1 cycle)
//   - PRESENT:
//     - hold term_char and term_valid stable until term_ready=1.
//     - On the handshake: term_valid<=0.
//       - fast=1: go IDLE.
//       - fast=0: load hold=PACE_CYCLES-1 and go HOLD.
//   - HOLD:
//     - decrement hold each clk7, independent of cpu_clken.
//     - go IDLE at hold==0, or immediately if fast is raised.
//  Latency, write to term_valid, empty FIFO and IDLE:
//   - write edge N, count=1 at N+1, FSM pops at N+1, term_valid=1 after edge N+2.
//  Pacing throughput: one char per PACE_CYCLES+2 cycles, given an immediate term_ready.
//  Simultaneous push and pop: count unchanged; the pushed char lands at the tail.
//  Flush (registered, priority over everything else):
//   - count=0, ovf=0, state=IDLE, term_valid=0 next cycle; last is kept.
//   - A write in the same cycle is discarded.
//  Pointers wrap modulo DEPTH. count is 5 bits and saturates structurally at DEPTH.
//  No combinational path from term_ready to dout or from bus inputs to term_valid.
// STRUCTURE
//  Shared package apple1_pkg holds:
//   - ADDR_KBD=16'hD010, ADDR_DSP=16'hD012
//   - CLK7_HZ, FRAME_HZ, PACE_DEFAULT
//   - ASCII_CR=7'h0D
//   - the FSM state enum {IDLE, PRESENT, HOLD}
//  One sub-module, apple1_sync_fifo (DEPTH, WIDTH=7):
//   - push/pop/flush, count, full/empty, registered head; used for the char queue.
//  Top-level integration replaces display_dout with this block's dout and feeds the terminal.
// TESTING
//  - Reset, then read $D012 and $D013 -> 8'h00 and 8'h00; term_valid=0.
//  - fast=1, write 8'hC1 to $D012, term_ready=1 -> term_valid at N+2 with term_char=7'h41, then low.
//  - fast=0, PACE_CYCLES=100, write 'A','B' -> 'B' presented 102 cycles after the 'A' handshake.
//  - term_ready=0, write 17 chars with DEPTH=16:
//    - $D012 bit7=1, $D013=8'h90
//    - reading $D013 clears ovf, next read gives 8'h10.
//  - FIFO full plus bus write on the same edge as the FSM pop -> write accepted, count stays 16, ovf stays 0.
//  - Midway through 5 queued chars with term_valid=1:
//    - flush -> term_valid=0 next cycle, $D013=8'h00.
//    - rst_n=0 mid-HOLD -> state IDLE.

Source files
------------

// File: rtl/apple1_pkg.sv
// Shared Apple-1 constants: bus addresses, clock/frame rates and the display port FSM states.
package apple1_pkg;

   localparam logic [15:0] ADDR_KBD     = 16'hD010;
   localparam logic [15:0] ADDR_DSP     = 16'hD012;
   localparam int          CLK7_HZ      = 7_000_000;
   localparam int          FRAME_HZ     = 60;
   // Rounded to nearest so one char per video frame at 7 MHz gives 116667.
   localparam int          PACE_DEFAULT = (CLK7_HZ + FRAME_HZ / 2) / FRAME_HZ;
   localparam logic [6:0]  ASCII_CR     = 7'h0D;

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      HOLD
   } dsp_state_e;

endpackage

// File: rtl/apple1_sync_fifo.sv
// Small synchronous FIFO for the display character queue; head is read from the storage registers.
module apple1_sync_fifo
   import apple1_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [4:0]       count,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [4:0]       count_q;
   logic             doPush;
   logic             doPop;

   assign full   = (count_q == 5'(DEPTH));
   assign empty  = (count_q == 5'd0);
   assign count  = count_q;
   assign head   = mem_q[rdPtr_q];
   // A push into a full queue is only legal when the head leaves on the same edge.
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);

   always_ff @(posedge clk) begin
      if (doPush && !flush) begin
         mem_q[wrPtr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/apple1_dsp_port.sv
// Apple-1 display port at $D012/$D013: buffers CPU writes and paces characters out to the terminal.
module apple1_dsp_port
   import apple1_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int PACE_CYCLES = PACE_DEFAULT
) (
   input  logic       clk7,
   input  logic       rst_n,
   input  logic       cpu_clken,
   input  logic       cs,
   input  logic       address,
   input  logic       we,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       fast,
   input  logic       flush,
   output logic       term_valid,
   output logic [6:0] term_char,
   input  logic       term_ready
);

   localparam int            HW        = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(PACE_CYCLES - 1);

   dsp_state_e    state_q;
   logic [HW-1:0] holdCnt_q;
   logic          termValid_q;
   logic [6:0]    termChar_q;
   logic          ovf_q, ovf_d;
   logic [6:0]    last_q, last_d;
   logic          wrDsp, rdCr, popNow, pushNow;
   logic          fifoFull, fifoEmpty;
   logic [4:0]    fifoCount;
   logic [6:0]    fifoHead;
   logic          unusedDin7;

   assign unusedDin7 = din[7];
   assign wrDsp      = cs && we && cpu_clken && !address;
   assign rdCr       = cs && !we && cpu_clken && address;
   assign popNow     = (state_q == IDLE) && !fifoEmpty && !flush;
   assign pushNow    = wrDsp && !flush && (!fifoFull || popNow);

   apple1_sync_fifo #(.DEPTH(DEPTH), .WIDTH(7)) u_fifo (
      .clk   (clk7),
      .rst_n (rst_n),
      .push  (pushNow),
      .pop   (popNow),
      .flush (flush),
      .din   (din[6:0]),
      .count (fifoCount),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .head  (fifoHead)
   );

   // A dropped write sets overflow even if $D013 is read on the same edge.
   always_comb begin
      ovf_d  = ovf_q;
      last_d = last_q;
      if (rdCr) ovf_d = 1'b0;
      if (wrDsp && !flush && !pushNow) ovf_d = 1'b1;
      if (flush) ovf_d = 1'b0;
      if (pushNow) last_d = din[6:0];
   end

   always_ff @(posedge clk7) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         last_q <= '0;
      end else begin
         ovf_q  <= ovf_d;
         last_q <= last_d;
      end
   end

   always_ff @(posedge clk7) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         holdCnt_q   <= '0;
         termValid_q <= 1'b0;
         termChar_q  <= '0;
      end else if (flush) begin
         state_q     <= IDLE;
         holdCnt_q   <= '0;
         termValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (popNow) begin
                  termChar_q  <= fifoHead;
                  termValid_q <= 1'b1;
                  state_q     <= PRESENT;
               end
            end
            PRESENT: begin
               if (term_ready) begin
                  termValid_q <= 1'b0;
                  if (fast) begin
                     state_q <= IDLE;
                  end else begin
                     holdCnt_q <= HOLD_LOAD;
                     state_q   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (fast || holdCnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  holdCnt_q <= holdCnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign term_valid = termValid_q;
   assign term_char  = termChar_q;

   always_comb begin
      dout = 8'h00;
      if (cs) begin
         dout = address ? {ovf_q, 2'b00, fifoCount} : {fifoFull, last_q};
      end
   end

endmodule

// File: tb/tb_apple1_dsp_port.sv
// Bench for apple1_dsp_port: directed scenarios plus random traffic against a queue-based reference model.
module tb_apple1_dsp_port;

   localparam int DEPTH = 16;
   localparam int PACE  = 100;

   logic       clk7 = 1'b0;
   logic       rst_n, cpu_clken, cs, address, we, fast, flush, term_ready;
   logic [7:0] din;
   logic [7:0] dout;
   logic       term_valid;
   logic [6:0] term_char;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hsCycle[$];

   // Reference model: queued chars, presented char, remaining pacing cycles.
   logic [6:0] mq[$];
   bit         mPresent;
   logic [6:0] mChar, mLast;
   bit         mOvf;
   int         mHoldLeft;

   apple1_dsp_port #(.DEPTH(DEPTH), .PACE_CYCLES(PACE)) dut (
      .clk7       (clk7),
      .rst_n      (rst_n),
      .cpu_clken  (cpu_clken),
      .cs         (cs),
      .address    (address),
      .we         (we),
      .din        (din),
      .dout       (dout),
      .fast       (fast),
      .flush      (flush),
      .term_valid (term_valid),
      .term_char  (term_char),
      .term_ready (term_ready)
   );

   always #5 clk7 = ~clk7;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] expDout(input logic csV, input logic addrV);
      int n = mq.size();
      if (!csV) return 8'h00;
      if (addrV) return {mOvf, 2'b00, 5'(n)};
      return {(n == DEPTH), mLast};
   endfunction

   // One clock: drive at negedge, advance the model, check #1 after the rising edge.
   task automatic applyStimulus(input logic rstV, input logic csV, input logic addrV, input logic weV,
                                input logic [7:0] dinV, input logic clkenV, input logic fastV,
                                input logic flushV, input logic readyV);
      bit wr, rdCr, pop, accept;
      @(negedge clk7);
      rst_n = rstV; cs = csV; address = addrV; we = weV; din = dinV;
      cpu_clken = clkenV; fast = fastV; flush = flushV; term_ready = readyV;
      if (rstV && !flushV && term_valid && readyV) hsCycle.push_back(cyc);
      wr   = csV && weV && clkenV && !addrV;
      rdCr = csV && !weV && clkenV && addrV;
      if (!rstV) begin
         mq.delete(); mPresent = 0; mChar = '0; mLast = '0; mOvf = 0; mHoldLeft = 0;
      end else if (flushV) begin
         mq.delete(); mPresent = 0; mOvf = 0; mHoldLeft = 0;
      end else begin
         pop    = !mPresent && mHoldLeft == 0 && mq.size() > 0;
         accept = wr && (mq.size() < DEPTH || pop);
         if (rdCr) mOvf = 0;
         if (wr && !accept) mOvf = 1;
         if (pop) begin
            mChar = mq.pop_front();
            mPresent = 1;
         end else if (mPresent) begin
            if (readyV) begin
               mPresent = 0;
               mHoldLeft = fastV ? 0 : PACE;
            end
         end else if (mHoldLeft > 0) begin
            mHoldLeft = fastV ? 0 : mHoldLeft - 1;
         end
         if (accept) begin
            mq.push_back(dinV[6:0]);
            mLast = dinV[6:0];
         end
      end
      @(posedge clk7);
      #1;
      cyc++;
      checkOutput("term_valid", term_valid, mPresent);
      checkOutput("term_char", term_char, mChar);
      checkOutput("dout", dout, expDout(csV, addrV));
   endtask

   task automatic writeChar(input logic [7:0] d, input logic fastV, input logic readyV);
      applyStimulus(1, 1, 0, 1, d, 1, fastV, 0, readyV);
   endtask

   task automatic idleCycle(input logic fastV, input logic readyV);
      applyStimulus(1, 0, 0, 0, 8'h00, 1, fastV, 0, readyV);
   endtask

   task automatic readReg(input logic addrV, input logic clkenV, input logic fastV, input logic readyV);
      applyStimulus(1, 1, addrV, 0, 8'h00, clkenV, fastV, 0, readyV);
   endtask

   initial begin
      bit found;
      rst_n = 0; cpu_clken = 0; cs = 0; address = 0; we = 0; din = '0;
      fast = 1; flush = 0; term_ready = 0;

      // Reset state
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
      readReg(0, 1, 1, 0);
      checkOutput("rstDsp", dout, 8'h00);
      readReg(1, 1, 1, 0);
      checkOutput("rstDspcr", dout, 8'h00);
      checkOutput("rstValid", term_valid, 1'b0);

      // Unpaced latency: write edge N, valid seen at edge N+2
      writeChar(8'hC1, 1, 1);
      checkOutput("latN", term_valid, 1'b0);
      idleCycle(1, 1);
      checkOutput("latValid", term_valid, 1'b1);
      checkOutput("latChar", term_char, 7'h41);
      idleCycle(1, 1);
      checkOutput("latDrop", term_valid, 1'b0);

      // Paced throughput
      hsCycle.delete();
      writeChar(8'h41, 0, 1);
      writeChar(8'h42, 0, 1);
      for (int i = 0; i < 300; i++) idleCycle(0, 1);
      checkOutput("paceHsCount", hsCycle.size(), 2);
      if (hsCycle.size() >= 2) checkOutput("paceGap", hsCycle[1] - hsCycle[0], PACE + 2);

      // Overflow while paced hold keeps the queue from draining
      writeChar(8'h5A, 0, 1);
      idleCycle(0, 1);
      idleCycle(0, 1);
      for (int i = 0; i < 17; i++) writeChar(8'h30 + 8'(i), 0, 0);
      readReg(0, 0, 0, 0);
      checkOutput("fullBusy", dout[7], 1'b1);
      readReg(1, 0, 0, 0);
      checkOutput("ovfStatus", dout, 8'h90);
      readReg(1, 1, 0, 0);
      checkOutput("ovfCleared", dout, 8'h10);

      // Write into a full queue on the same edge as the pop
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (!mPresent && mHoldLeft == 0 && mq.size() > 0) found = 1;
         else idleCycle(0, 0);
      end
      checkOutput("fullPopReach", found, 1'b1);
      writeChar(8'h57, 0, 0);
      readReg(1, 0, 0, 0);
      checkOutput("fullPopStatus", dout, 8'h10);
      checkOutput("fullPopValid", term_valid, 1'b1);

      // Flush midway through queued chars
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) writeChar(8'h61 + 8'(i), 1, 0);
      idleCycle(1, 1);
      idleCycle(1, 0);
      checkOutput("preFlushValid", term_valid, 1'b1);
      applyStimulus(1, 1, 1, 1, 8'h7A, 0, 1, 1, 0);
      checkOutput("flushValid", term_valid, 1'b0);
      checkOutput("flushStatus", dout, 8'h00);

      // Reset in the middle of a pacing hold returns to idle
      writeChar(8'h52, 0, 1);
      for (int i = 0; i < 5; i++) idleCycle(0, 1);
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      writeChar(8'h53, 0, 0);
      idleCycle(0, 0);
      checkOutput("rstHoldValid", term_valid, 1'b1);
      checkOutput("rstHoldChar", term_char, 7'h53);

      // Random traffic
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         applyStimulus(($urandom_range(0, 299) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 15) != 0), ($urandom_range(0, 149) == 0),
                       ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
